// File: rtl/ni_tdm_arbiter.sv
// ---------------------------------------------------------------------------
// ni_tdm_arbiter
//
// Time-division-multiplexed arbiter that shares one NI write port between
// NUM_REQ core-side requesters. A free-running slot counter picks the slot
// owner each cycle (owner = low REQ_W bits of the counter). A granted word is
// registered onto the NI port one cycle after its handshake, and ni_wfull
// backpressure freezes the presented word until the NI accepts it.
//
// Handshake: requester i transfers a word in any cycle where req_valid_i[i]
// and req_ready_o[i] are both 1. req_ready is combinational, at most one bit
// is set per cycle, and a requester keeps its data stable until it sees
// ready. The NI side consumes the presented word in any cycle where ni_wen_o
// is 1 and ni_wfull_i is 0.
//
// Optional feature (compile-time macro): WORK_CONSERVE_EN
//   undefined : strict TDM, an idle owner slot produces no NI write.
//   defined   : if the owner is idle, the first valid requester searching
//               round-robin from owner+1 is granted instead.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   req_valid_i  per-requester write request            [NUM_REQ]
//   req_wdata_i  packed write data, slice i at i*RSIZE  [NUM_REQ*RSIZE]
//   req_waddr_i  packed write address, same packing     [NUM_REQ*RSIZE]
//   req_ready_o  one-hot accept strobe (combinational)  [NUM_REQ]
//   ni_wfull_i   NI write side full
//   ni_wen_o     registered NI write strobe
//   ni_wdata_o   registered NI write data               [RSIZE]
//   ni_waddr_o   registered NI write address            [RSIZE]
//   cur_slot_o   current slot counter value             [MSB_SLOT]
//   grant_id_o   requester whose word is on the NI port [REQ_W]
//   stall_cnt_o  saturating count of cycles spent in HOLD [16]
//   state_o      FSM state (debug visibility)           [2]
// ---------------------------------------------------------------------------
module ni_tdm_arbiter #(
   parameter int ADDRSIZE = 5,
   parameter int MSB_SLOT = 5,
   parameter int NUM_REQ  = 4,
   localparam int RSIZE   = 2 ** (MSB_SLOT - 1),
   localparam int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ*RSIZE-1:0]   req_wdata_i,
   input  logic [NUM_REQ*RSIZE-1:0]   req_waddr_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic                       ni_wfull_i,
   output logic                       ni_wen_o,
   output logic [RSIZE-1:0]           ni_wdata_o,
   output logic [RSIZE-1:0]           ni_waddr_o,
   output logic [MSB_SLOT-1:0]        cur_slot_o,
   output logic [REQ_W-1:0]           grant_id_o,
   output logic [15:0]                stall_cnt_o,
   output logic [1:0]                 state_o
);

   // Elaboration-time sanity guards; an illegal configuration yields an
   // empty, clearly named generate scope.
   if (ADDRSIZE < 1) begin : g_bad_addrsize
   end
   if ((NUM_REQ & (NUM_REQ - 1)) != 0 || NUM_REQ > 2 ** MSB_SLOT) begin : g_bad_num_req
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [MSB_SLOT-1:0]   slot_q;
   logic                  ni_wen_q;
   logic [RSIZE-1:0]      ni_wdata_q, ni_waddr_q;
   logic [REQ_W-1:0]      grant_id_q;
   logic [15:0]           stall_cnt_q;

   logic [REQ_W-1:0]      owner;
   logic                  can_issue;
   logic                  grant_valid;
   logic [REQ_W-1:0]      grant_idx;
`ifdef WORK_CONSERVE_EN
   logic [REQ_W-1:0]      search_idx;
`endif

   // ------------------------------------------------------------------
   // Grant selection
   // ------------------------------------------------------------------
   always_comb begin
      owner       = slot_q[REQ_W-1:0];
      // No grant while a presented word is being refused, and none while
      // reset is held low.
      can_issue   = !(ni_wen_q && ni_wfull_i) && reset;
      grant_valid = 1'b0;
      grant_idx   = owner;
`ifdef WORK_CONSERVE_EN
      search_idx  = owner;
`endif
      if (can_issue) begin
         if (req_valid_i[owner]) begin
            grant_valid = 1'b1;
         end
`ifdef WORK_CONSERVE_EN
         else begin
            // Index arithmetic wraps naturally at REQ_W bits (NUM_REQ is a
            // power of two), giving the round-robin order owner+1, owner+2...
            for (int k = 1; k < NUM_REQ; k++) begin
               search_idx = owner + REQ_W'(k);
               if (!grant_valid && req_valid_i[search_idx]) begin
                  grant_valid = 1'b1;
                  grant_idx   = search_idx;
               end
            end
         end
`endif
      end
   end

   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_valid && (grant_idx == REQ_W'(i))) begin
            req_ready_o[i] = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_valid) state_d = ST_SEND;
         end
         ST_SEND: begin
            if (ni_wfull_i)       state_d = ST_HOLD;
            else if (grant_valid) state_d = ST_SEND;
            else                  state_d = ST_IDLE;
         end
         ST_HOLD: begin
            // Once the NI takes the frozen word, a grant issued in this
            // same cycle is safe to load.
            if (!ni_wfull_i) state_d = grant_valid ? ST_SEND : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         slot_q      <= '0;
         ni_wen_q    <= 1'b0;
         ni_wdata_q  <= '0;
         ni_waddr_q  <= '0;
         grant_id_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         // TDM time is global: the slot counter never stalls.
         slot_q   <= slot_q + MSB_SLOT'(1);
         ni_wen_q <= (state_d != ST_IDLE);
         if (grant_valid) begin
            ni_wdata_q <= req_wdata_i[grant_idx*RSIZE +: RSIZE];
            ni_waddr_q <= req_waddr_i[grant_idx*RSIZE +: RSIZE];
            grant_id_q <= grant_idx;
         end
         if (state_q == ST_HOLD && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign ni_wen_o    = ni_wen_q;
   assign ni_wdata_o  = ni_wdata_q;
   assign ni_waddr_o  = ni_waddr_q;
   assign cur_slot_o  = slot_q;
   assign grant_id_o  = grant_id_q;
   assign stall_cnt_o = stall_cnt_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_ni_tdm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ni_tdm_arbiter
//
// Directed bench for ni_tdm_arbiter at default parameters (MSB_SLOT=5,
// NUM_REQ=4, RSIZE=16). Inputs are driven on the falling edge; outputs are
// sampled on the falling edge (registered) or 1 time unit after an input
// change (combinational req_ready).
// ---------------------------------------------------------------------------
module tb_ni_tdm_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [63:0] req_wdata;
   logic [63:0] req_waddr;
   logic [3:0]  req_ready;
   logic        ni_wfull;
   logic        ni_wen;
   logic [15:0] ni_wdata;
   logic [15:0] ni_waddr;
   logic [4:0]  cur_slot;
   logic [1:0]  grant_id;
   logic [15:0] stall_cnt;
   logic [1:0]  state_dbg;

   int tests_run;
   int tests_failed;

   ni_tdm_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid_i (req_valid),
      .req_wdata_i (req_wdata),
      .req_waddr_i (req_waddr),
      .req_ready_o (req_ready),
      .ni_wfull_i  (ni_wfull),
      .ni_wen_o    (ni_wen),
      .ni_wdata_o  (ni_wdata),
      .ni_waddr_o  (ni_waddr),
      .cur_slot_o  (cur_slot),
      .grant_id_o  (grant_id),
      .stall_cnt_o (stall_cnt),
      .state_o     (state_dbg)
   );

   // Clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Driver tasks
   task automatic set_req(input int i, input logic [15:0] d, input logic [15:0] a);
      req_wdata[i*16 +: 16] = d;
      req_waddr[i*16 +: 16] = a;
   endtask

   // Leaves the bench at a falling edge with reset released and cur_slot=0.
   task automatic do_reset();
      reset     = 1'b0;
      req_valid = 4'b0000;
      ni_wfull  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_slot(input logic [4:0] s);
      int n;
      n = 0;
      while (cur_slot !== s && n < 64) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (cur_slot !== s) begin
         tests_failed++;
         $display("FAIL wait_slot: cur_slot=%0d required %0d", cur_slot, s);
      end
   endtask

   // Scenario tasks
   task automatic test_reset();
      reset     = 1'b0;
      ni_wfull  = 1'b0;
      req_wdata = 64'h1111_2222_3333_4444;
      req_waddr = 64'h5555_6666_7777_8888;
      req_valid = 4'b1111;
      repeat (2) @(negedge clk);
      tests_run++; if (ni_wen !== 1'b0) begin tests_failed++; $display("FAIL reset_wen: got %b required 0", ni_wen); end
      tests_run++; if (ni_wdata !== 16'h0) begin tests_failed++; $display("FAIL reset_wdata: got %h required 0000", ni_wdata); end
      tests_run++; if (cur_slot !== 5'd0) begin tests_failed++; $display("FAIL reset_slot: got %0d required 0", cur_slot); end
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready: got %b required 0000", req_ready); end
      tests_run++; if (stall_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_stall: got %h required 0000", stall_cnt); end
      req_valid = 4'b0000;
      reset     = 1'b1;
      @(negedge clk);
      tests_run++; if (cur_slot !== 5'd1) begin tests_failed++; $display("FAIL release_slot: got %0d required 1", cur_slot); end
   endtask

   task automatic test_single_grant();
      do_reset();
      set_req(2, 16'hAAAA, 16'hBBBB);
      req_valid = 4'b0100;
      #1;
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL single_slot0_ready: got %b required 0000", req_ready); end
      @(negedge clk);
      @(negedge clk); // slot 2
      tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_slot2_ready: got %b required 0100", req_ready); end
      @(negedge clk); // slot 3
      req_valid = 4'b0000;
      tests_run++; if (ni_wen !== 1'b1) begin tests_failed++; $display("FAIL single_wen: got %b required 1", ni_wen); end
      tests_run++; if (ni_wdata !== 16'hAAAA) begin tests_failed++; $display("FAIL single_wdata: got %h required aaaa", ni_wdata); end
      tests_run++; if (ni_waddr !== 16'hBBBB) begin tests_failed++; $display("FAIL single_waddr: got %h required bbbb", ni_waddr); end
      tests_run++; if (grant_id !== 2'd2) begin tests_failed++; $display("FAIL single_gid: got %0d required 2", grant_id); end
      @(negedge clk); // slot 4
      tests_run++; if (ni_wen !== 1'b0) begin tests_failed++; $display("FAIL single_wen_off: got %b required 0", ni_wen); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_req(0, 16'hABBA, 16'h0010);
      set_req(1, 16'hCCCC, 16'h0011);
      req_valid = 4'b0011;
      #1;
      tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL b2b_ready0: got %b required 0001", req_ready); end
      @(negedge clk); // slot 1
      req_valid = 4'b0010;
      #1;
      tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL b2b_ready1: got %b required 0010", req_ready); end
      tests_run++; if (ni_wen !== 1'b1 || ni_wdata !== 16'hABBA || grant_id !== 2'd0) begin tests_failed++; $display("FAIL b2b_word0: got wen=%b data=%h gid=%0d required 1/abba/0", ni_wen, ni_wdata, grant_id); end
      @(negedge clk); // slot 2
      req_valid = 4'b0000;
      tests_run++; if (ni_wen !== 1'b1 || ni_wdata !== 16'hCCCC || grant_id !== 2'd1) begin tests_failed++; $display("FAIL b2b_word1: got wen=%b data=%h gid=%0d required 1/cccc/1", ni_wen, ni_wdata, grant_id); end
      @(negedge clk); // slot 3
      tests_run++; if (ni_wen !== 1'b0) begin tests_failed++; $display("FAIL b2b_done: got %b required 0", ni_wen); end
      repeat (3) @(negedge clk); // slot 6
      tests_run++; if (ni_wen !== 1'b0) begin tests_failed++; $display("FAIL b2b_no_repeat: got %b required 0", ni_wen); end
   endtask

   task automatic test_backpressure();
      do_reset();
      set_req(0, 16'hABBA, 16'h0033);
      req_valid = 4'b0001;
      @(negedge clk); // slot 1, SEND
      req_valid = 4'b0010;
      set_req(1, 16'hCCCC, 16'h0044);
      ni_wfull = 1'b1;
      #1;
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_send_full_ready: got %b required 0000", req_ready); end
      @(negedge clk); // slot 2, HOLD
      req_valid = 4'b1111;
      #1;
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_hold_ready: got %b required 0000", req_ready); end
      tests_run++; if (ni_wen !== 1'b1 || ni_wdata !== 16'hABBA) begin tests_failed++; $display("FAIL bp_hold_word: got wen=%b data=%h required 1/abba", ni_wen, ni_wdata); end
      @(negedge clk); // slot 3, HOLD
      tests_run++; if (stall_cnt !== 16'd1) begin tests_failed++; $display("FAIL bp_stall_mid: got %0d required 1", stall_cnt); end
      tests_run++; if (ni_wdata !== 16'hABBA || ni_waddr !== 16'h0033) begin tests_failed++; $display("FAIL bp_frozen: got %h/%h required abba/0033", ni_wdata, ni_waddr); end
      @(negedge clk); // slot 4, HOLD, NI drains
      ni_wfull  = 1'b0;
      req_valid = 4'b0000;
      tests_run++; if (ni_wen !== 1'b1) begin tests_failed++; $display("FAIL bp_wen_held: got %b required 1", ni_wen); end
      @(negedge clk); // slot 5
      tests_run++; if (ni_wen !== 1'b0) begin tests_failed++; $display("FAIL bp_complete: got %b required 0", ni_wen); end
      tests_run++; if (stall_cnt !== 16'd3) begin tests_failed++; $display("FAIL bp_stall_cnt: got %0d required 3", stall_cnt); end
      @(negedge clk); // slot 6: missed slot of requester 1 never granted later
      tests_run++; if (ni_wen !== 1'b0 || grant_id !== 2'd0) begin tests_failed++; $display("FAIL bp_missed_slot: got wen=%b gid=%0d required 0/0", ni_wen, grant_id); end
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      set_req(0, 16'hBEEF, 16'h0055);
      req_valid = 4'b0001;
      @(negedge clk); // slot 1, SEND
      req_valid = 4'b0000;
      ni_wfull  = 1'b1;
      @(negedge clk); // slot 2, HOLD
      tests_run++; if (ni_wen !== 1'b1) begin tests_failed++; $display("FAIL rh_in_hold: got %b required 1", ni_wen); end
      reset    = 1'b0;
      ni_wfull = 1'b0;
      @(negedge clk);
      tests_run++; if (ni_wen !== 1'b0 || stall_cnt !== 16'd0 || ni_wdata !== 16'h0) begin tests_failed++; $display("FAIL rh_cleared: got wen=%b stall=%0d data=%h required 0/0/0000", ni_wen, stall_cnt, ni_wdata); end
      tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL rh_state: got %0d required 0", state_dbg); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++; if (ni_wen !== 1'b0) begin tests_failed++; $display("FAIL rh_no_replay: got %b required 0", ni_wen); end
   endtask

   task automatic test_idle_owner();
      do_reset();
      set_req(3, 16'h1234, 16'h5678);
      req_valid = 4'b1000;
      #1;
`ifdef WORK_CONSERVE_EN
      tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL wc_ready_slot0: got %b required 1000", req_ready); end
      @(negedge clk); // slot 1
      req_valid = 4'b0000;
      tests_run++; if (ni_wen !== 1'b1 || grant_id !== 2'd3 || ni_wdata !== 16'h1234) begin tests_failed++; $display("FAIL wc_word: got wen=%b gid=%0d data=%h required 1/3/1234", ni_wen, grant_id, ni_wdata); end
`else
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL tdm_ready_slot0: got %b required 0000", req_ready); end
      repeat (3) @(negedge clk); // slot 3
      tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL tdm_ready_slot3: got %b required 1000", req_ready); end
      @(negedge clk); // slot 4
      req_valid = 4'b0000;
      tests_run++; if (ni_wen !== 1'b1 || grant_id !== 2'd3 || ni_wdata !== 16'h1234) begin tests_failed++; $display("FAIL tdm_word: got wen=%b gid=%0d data=%h required 1/3/1234", ni_wen, grant_id, ni_wdata); end
`endif
      wait_slot(5'd31);
      @(negedge clk);
      tests_run++; if (cur_slot !== 5'd0) begin tests_failed++; $display("FAIL wrap_slot: got %0d required 0", cur_slot); end
      set_req(0, 16'h0F0F, 16'h00F0);
      req_valid = 4'b0001;
      #1;
      tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL wrap_owner0: got %b required 0001", req_ready); end
      @(negedge clk);
      req_valid = 4'b0000;
      tests_run++; if (ni_wen !== 1'b1 || grant_id !== 2'd0 || ni_wdata !== 16'h0F0F) begin tests_failed++; $display("FAIL wrap_word: got wen=%b gid=%0d data=%h required 1/0/0f0f", ni_wen, grant_id, ni_wdata); end
   endtask

   // Sequence and final report
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      req_valid    = 4'b0000;
      req_wdata    = '0;
      req_waddr    = '0;
      ni_wfull     = 1'b0;
      test_reset();
      test_single_grant();
      test_back_to_back();
      test_backpressure();
      test_reset_in_hold();
      test_idle_owner();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
